// File: rtl/ccip_mmio_bridge_if.sv
// ccip_mmio_bridge_if: host request/response, CCI-P c0 MMIO request and c2 read-response signals.
interface ccip_mmio_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int TID_WIDTH  = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_len;
    logic [63:0]           req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_data;
    logic                  rsp_timeout;
    logic                  rsp_err;
    logic                  c0_busy;
    logic                  mmio_wr_valid;
    logic                  mmio_rd_valid;
    logic [ADDR_WIDTH-1:0] mmio_addr;
    logic [1:0]            mmio_length;
    logic [TID_WIDTH-1:0]  mmio_tid;
    logic [511:0]          mmio_data;
    logic                  c2_rd_valid;
    logic [TID_WIDTH-1:0]  c2_tid;
    logic [63:0]           c2_data;
    logic [7:0]            stray_cnt;
    logic                  align_err;

    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_data, rsp_ready, c0_busy,
               c2_rd_valid, c2_tid, c2_data,
        output req_ready, rsp_valid, rsp_data, rsp_timeout, rsp_err, mmio_wr_valid,
               mmio_rd_valid, mmio_addr, mmio_length, mmio_tid, mmio_data, stray_cnt, align_err
    );

    modport master (
        output req_valid, req_write, req_addr, req_len, req_data, rsp_ready, c0_busy,
               c2_rd_valid, c2_tid, c2_data,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout, rsp_err, mmio_wr_valid,
               mmio_rd_valid, mmio_addr, mmio_length, mmio_tid, mmio_data, stray_cnt, align_err
    );
endinterface

// File: rtl/ccip_mmio_bridge.sv
// ccip_mmio_bridge: host MMIO transactions to CCI-P c0 MMIO pulses, with c2 read-response tracking.
// Define CCIP_MMIO_BRIDGE_TIMEOUT_EN to add the read-response timeout.
module ccip_mmio_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TID_WIDTH      = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic reset,
    ccip_mmio_bridge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RSP} state_t;

    state_t                state_q;
    logic                  write_q, len_q, req_ready_q, rsp_valid_q, rsp_err_q, align_err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [63:0]           data_q, rsp_data_q;
    logic [TID_WIDTH-1:0]  tid_q, exp_tid_q, mmio_tid_q;
    logic [7:0]            stray_q;
    logic                  hs, misaligned, issue_go, match;

    assign hs         = state_q == IDLE && req_ready_q && bus.req_valid;
    assign misaligned = bus.req_len && bus.req_addr[0];
    assign issue_go   = state_q == ISSUE && !bus.c0_busy;
    assign match      = state_q == WAIT_RSP && bus.c2_rd_valid && bus.c2_tid == exp_tid_q;

`ifdef CCIP_MMIO_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] timer_q;
    logic          rsp_timeout_q;
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // The issue pulse must react to c0_busy in the same cycle, so it is gated combinationally.
    assign bus.mmio_wr_valid = reset && issue_go && write_q;
    assign bus.mmio_rd_valid = reset && issue_go && !write_q;
    assign bus.mmio_addr     = addr_q;
    assign bus.mmio_length   = {1'b0, len_q};
    assign bus.mmio_tid      = mmio_tid_q;
    assign bus.mmio_data     = {448'b0, data_q};
    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.stray_cnt     = stray_q;
    assign bus.align_err     = align_err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            len_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            align_err_q <= 1'b0;
            tid_q       <= '0;
            exp_tid_q   <= '0;
            mmio_tid_q  <= '0;
            stray_q     <= '0;
`ifdef CCIP_MMIO_BRIDGE_TIMEOUT_EN
            timer_q       <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            if (bus.c2_rd_valid && !match && stray_q != 8'hff)
                stray_q <= stray_q + 8'd1;
            case (state_q)
                IDLE: begin
                    if (!hs) begin
                        req_ready_q <= 1'b1;
                    end else if (misaligned) begin
                        align_err_q <= 1'b1;
                        if (!bus.req_write) begin
                            state_q     <= RSP;
                            req_ready_q <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '1;
                        end
                    end else begin
                        state_q     <= ISSUE;
                        req_ready_q <= 1'b0;
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        len_q       <= bus.req_len;
                        data_q      <= bus.req_data;
                        mmio_tid_q  <= tid_q;
                    end
                end
                ISSUE: begin
                    if (issue_go && write_q) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end else if (issue_go) begin
                        state_q   <= WAIT_RSP;
                        exp_tid_q <= tid_q;
                        tid_q     <= tid_q + 1'b1;
`ifdef CCIP_MMIO_BRIDGE_TIMEOUT_EN
                        timer_q <= '0;
`endif
                    end
                end
                WAIT_RSP: begin
                    if (match) begin
                        state_q     <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= len_q ? bus.c2_data : {32'b0, bus.c2_data[31:0]};
`ifdef CCIP_MMIO_BRIDGE_TIMEOUT_EN
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q       <= RSP;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_data_q    <= '1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
`endif
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
`ifdef CCIP_MMIO_BRIDGE_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ccip_mmio_bridge.sv
// tb_ccip_mmio_bridge: directed vector table plus hand sequences for stalls, strays, timeout, tid wrap and reset.
module tb_ccip_mmio_bridge;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [8:0] tid_exp = '0;
    logic align_exp = 1'b0;
    int stray_exp = 0;

    always #5 clk = ~clk;

    ccip_mmio_bridge_if bus ();

    ccip_mmio_bridge #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic        len;
        logic [63:0] wdata;
        int          busy;
        int          dly;
        logic [63:0] c2d;
        logic        pulse;
        logic [8:0]  tid;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            cyc();
            n++;
        end
        chk("req_ready_wait", bus.req_ready, 1);
    endtask

    task automatic drive_req(input logic wr, input logic [15:0] addr, input logic len, input logic [63:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_data  = d;
    endtask

    // Handshake a busy-free request and stop at the negedge of the pulse cycle.
    task automatic issue(input logic wr, input logic [15:0] addr, input logic len, input logic [63:0] d);
        wait_ready();
        drive_req(wr, addr, len, d);
        cyc();
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_rsp();
        cyc();
        @(negedge clk);
        chk("rsp_hold", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_rsp", bus.req_ready, 1);
        chk("rsp_clear", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 0);
    endtask

    task automatic respond(input logic [8:0] tid, input logic [63:0] d);
        bus.c2_rd_valid = 1'b1;
        bus.c2_tid      = tid;
        bus.c2_data     = d;
        cyc();
        bus.c2_rd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input vec_t v);
        wait_ready();
        drive_req(v.wr, v.addr, v.len, v.wdata);
        bus.c0_busy = v.busy != 0;
        cyc();
        bus.req_valid = 1'b0;
        for (int k = 0; k < v.busy; k++) begin
            @(negedge clk);
            chk("busy_nopulse", bus.mmio_wr_valid | bus.mmio_rd_valid, 0);
            chk("busy_addr", bus.mmio_addr, v.addr);
            cyc();
        end
        bus.c0_busy = 1'b0;
        @(negedge clk);
        chk("wr_pulse", bus.mmio_wr_valid, v.pulse && v.wr);
        chk("rd_pulse", bus.mmio_rd_valid, v.pulse && !v.wr);
        if (!v.pulse) align_exp = 1'b1;
        chk("align_err", bus.align_err, align_exp);
        if (v.pulse) begin
            chk("mmio_addr", bus.mmio_addr, v.addr);
            chk("mmio_length", bus.mmio_length, {1'b0, v.len});
        end
        if (v.wr) begin
            if (v.pulse) begin
                chk("mmio_data_lo", bus.mmio_data[63:0], v.wdata);
                chk("mmio_data_hi", |bus.mmio_data[511:64], 0);
                cyc();
                @(negedge clk);
                chk("wr_no_repulse", bus.mmio_wr_valid, 0);
            end
            chk("wr_ready", bus.req_ready, 1);
            chk("wr_no_rsp", bus.rsp_valid, 0);
        end else if (!v.pulse) begin
            chk("err_rsp_valid", bus.rsp_valid, 1);
            chk("err_rsp_err", bus.rsp_err, 1);
            chk("err_rsp_data", bus.rsp_data, v.rdata);
            finish_rsp();
        end else begin
            chk("mmio_tid", bus.mmio_tid, v.tid);
            tid_exp = v.tid + 9'd1;
            repeat (v.dly) cyc();
            bus.c2_rd_valid = 1'b1;
            bus.c2_tid      = v.tid;
            bus.c2_data     = v.c2d;
            @(negedge clk);
            chk("rsp_not_early", bus.rsp_valid, 0);
            cyc();
            bus.c2_rd_valid = 1'b0;
            @(negedge clk);
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_data", bus.rsp_data, v.rdata);
            chk("rsp_flags", {bus.rsp_err, bus.rsp_timeout}, 0);
            finish_rsp();
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = 1'b0;
        bus.req_data    = '0;
        bus.rsp_ready   = 1'b0;
        bus.c0_busy     = 1'b0;
        bus.c2_rd_valid = 1'b0;
        bus.c2_tid      = '0;
        bus.c2_data     = '0;

        vecs[0] = '{1'b1, 16'h0010, 1'b1, 64'h1122334455667788, 0, 0, 64'h0, 1'b1, 9'd0, 64'h0};
        vecs[1] = '{1'b0, 16'h0004, 1'b0, 64'h0, 0, 3, 64'hDEADBEEFCAFEF00D, 1'b1, 9'd0, 64'h00000000CAFEF00D};
        vecs[2] = '{1'b0, 16'h0008, 1'b1, 64'h0, 0, 1, 64'h0123456789ABCDEF, 1'b1, 9'd1, 64'h0123456789ABCDEF};
        vecs[3] = '{1'b1, 16'h0005, 1'b0, 64'h00000000AAAA5555, 5, 0, 64'h0, 1'b1, 9'd0, 64'h0};
        vecs[4] = '{1'b0, 16'h0003, 1'b1, 64'h0, 0, 0, 64'h0, 1'b0, 9'd0, 64'hFFFFFFFFFFFFFFFF};
        vecs[5] = '{1'b0, 16'h0007, 1'b0, 64'h0, 2, 1, 64'hFFFFFFFF12345678, 1'b1, 9'd2, 64'h0000000012345678};
        vecs[6] = '{1'b1, 16'h0001, 1'b1, 64'h99, 0, 0, 64'h0, 1'b0, 9'd0, 64'h0};
        vecs[7] = '{1'b0, 16'h0002, 1'b1, 64'h0, 0, 5, 64'h5A5A5A5AA5A5A5A5, 1'b1, 9'd3, 64'h5A5A5A5AA5A5A5A5};

        repeat (3) cyc();
        @(negedge clk);
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_pulses", {bus.mmio_wr_valid, bus.mmio_rd_valid}, 0);
        chk("reset_hdr", {bus.mmio_addr, bus.mmio_length, bus.mmio_tid}, 0);
        chk("reset_mmio_data", |bus.mmio_data, 0);
        chk("reset_stray_align", {bus.stray_cnt, bus.align_err}, 0);
        cyc();
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run(vecs[i]);

        // c2 response while idle counts as stray
        wait_ready();
        respond(9'd0, 64'h1);
        stray_exp++;
        chk("stray_idle", bus.stray_cnt, stray_exp);

        // wrong tid while waiting is stray, then the right one completes
        issue(1'b0, 16'h0040, 1'b0, 64'h0);
        chk("stray_seq_tid", bus.mmio_tid, tid_exp);
        cyc();
        respond(tid_exp + 9'd1, 64'h55);
        stray_exp++;
        chk("stray_wait", bus.stray_cnt, stray_exp);
        chk("stray_no_rsp", bus.rsp_valid, 0);
        cyc();
        respond(tid_exp, 64'hAAAAAAAA00000077);
        chk("stray_then_match", bus.rsp_data, 64'h77);
        finish_rsp();
        tid_exp++;

`ifdef CCIP_MMIO_BRIDGE_TIMEOUT_EN
        begin
            logic early = 1'b0;
            issue(1'b0, 16'h0050, 1'b0, 64'h0);
            chk("to_pulse", bus.mmio_rd_valid, 1);
            repeat (16) begin
                cyc();
                @(negedge clk);
                early |= bus.rsp_valid;
            end
            chk("to_early", early, 0);
            cyc();
            @(negedge clk);
            chk("to_valid", bus.rsp_valid, 1);
            chk("to_flag", bus.rsp_timeout, 1);
            chk("to_data", bus.rsp_data, 64'hFFFFFFFFFFFFFFFF);
            finish_rsp();
            respond(tid_exp, 64'h1);
            stray_exp++;
            chk("to_late_stray", bus.stray_cnt, stray_exp);
            tid_exp++;
            issue(1'b0, 16'h0054, 1'b1, 64'h0);
            repeat (16) cyc();
            respond(tid_exp, 64'h0BADF00D0BADF00D);
            chk("to_edge_valid", bus.rsp_valid, 1);
            chk("to_edge_flag", bus.rsp_timeout, 0);
            chk("to_edge_data", bus.rsp_data, 64'h0BADF00D0BADF00D);
            finish_rsp();
            tid_exp++;
        end
`else
        issue(1'b0, 16'h0050, 1'b0, 64'h0);
        repeat (40) cyc();
        @(negedge clk);
        chk("noto_waiting", bus.rsp_valid, 0);
        chk("noto_flag", bus.rsp_timeout, 0);
        cyc();
        respond(tid_exp, 64'h0000000100000002);
        chk("noto_data", bus.rsp_data, 64'h2);
        finish_rsp();
        tid_exp++;
`endif

        // run enough reads to wrap the 9-bit tid
        for (int i = 0; i < 520; i++) begin
            issue(1'b0, 16'h0020, 1'b0, 64'h0);
            chk("wrap_tid", bus.mmio_tid, tid_exp);
            cyc();
            respond(tid_exp, {32'hFFFFFFFF, 32'(i)});
            chk("wrap_rsp", bus.rsp_data, 64'(i));
            bus.rsp_ready = 1'b1;
            cyc();
            bus.rsp_ready = 1'b0;
            tid_exp++;
        end

        wait_ready();
        bus.c2_rd_valid = 1'b1;
        repeat (300) cyc();
        bus.c2_rd_valid = 1'b0;
        @(negedge clk);
        chk("stray_saturate", bus.stray_cnt, 255);

        // reset while a write waits in ISSUE must suppress the pulse
        wait_ready();
        drive_req(1'b1, 16'h0030, 1'b0, 64'h5);
        bus.c0_busy = 1'b1;
        cyc();
        bus.req_valid = 1'b0;
        bus.c0_busy   = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        chk("rst_no_wr_pulse", bus.mmio_wr_valid, 0);
        cyc();
        @(negedge clk);
        chk("rst_ready_low", bus.req_ready, 0);
        chk("rst_clear_stray_align", {bus.stray_cnt, bus.align_err}, 0);
        reset = 1'b1;

        // reset while a read waits for its response abandons it and restarts tid at 0
        issue(1'b0, 16'h0034, 1'b0, 64'h0);
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_no_rsp", bus.rsp_valid, 0);
        issue(1'b0, 16'h0038, 1'b0, 64'h0);
        chk("rst_tid_zero", bus.mmio_tid, 0);
        cyc();
        respond(9'd0, 64'h1234);
        chk("rst_rsp", bus.rsp_data, 64'h1234);
        finish_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccip_mmio_bridge.md
# ccip_mmio_bridge

Converts single host-side MMIO transactions (from the OPAE simulator's driver model) into the flattened CCI-P channel-0 MMIO request signals consumed by `vortex_afu_shim`. It also collects the matching channel-2 read responses from the shim. The bridge sits directly upstream of the shim's `vcp2af_sRxPort_c0_*` MMIO inputs and directly downstream of its `af2cp_sTxPort_c2_*` outputs. It tracks transaction IDs, enforces one outstanding read, and times out lost reads.

## Interface
- `ADDR_WIDTH`, default 16: MMIO DWORD address width (`t_ccip_mmioAddr`).
- `TID_WIDTH`, default 9: transaction ID width (`t_ccip_tid`).
- `TIMEOUT_CYCLES`, default 1024: read response wait limit; must be ≥ 2.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low.
- `req_valid`, in, 1: host request valid.
- `req_ready`, out, 1: request accepted when high together with `req_valid`.
- `req_write`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, `ADDR_WIDTH`: DWORD address.
- `req_len`, in, 1: 0 = 4B, 1 = 8B.
- `req_data`, in, 64: write data.
- `rsp_valid`, out, 1: read response valid; held until `rsp_ready`.
- `rsp_ready`, in, 1: host accepts the read response.
- `rsp_data`, out, 64: read data; 4B reads are zero-extended.
- `rsp_timeout`, out, 1: response produced by timeout; `rsp_data` = all ones.
- `rsp_err`, out, 1: misaligned read; `rsp_data` = all ones.
- `c0_busy`, in, 1: channel 0 carries a memory response this cycle; MMIO issue is held off.
- `mmio_wr_valid`, out, 1: drives `vcp2af_sRxPort_c0_mmioWrValid`.
- `mmio_rd_valid`, out, 1: drives `vcp2af_sRxPort_c0_mmioRdValid`.
- `mmio_addr`, out, `ADDR_WIDTH`: drives `ReqMmioHdr_address`.
- `mmio_length`, out, 2: drives `ReqMmioHdr_length`; 0 = 4B, 1 = 8B.
- `mmio_tid`, out, `TID_WIDTH`: drives `ReqMmioHdr_tid`.
- `mmio_data`, out, 512: drives `c0_data`; bits [63:0] = write data, all other bits 0.
- `c2_rd_valid`, in, 1: from `af2cp_sTxPort_c2_mmioRdValid`.
- `c2_tid`, in, `TID_WIDTH`: from `af2cp_sTxPort_c2_hdr_tid`.
- `c2_data`, in, 64: from `af2cp_sTxPort_c2_data`.
- `stray_cnt`, out, 8: saturating count of c2 responses with an unexpected tid or arriving outside WAIT_RSP.
- `align_err`, out, 1: sticky flag; set by any misaligned request, cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, RSP.
- IDLE:
  - `req_ready` = 1.
  - On handshake, capture write/addr/len/data into header registers.
  - A request is misaligned when `req_len` = 1 and `req_addr[0]` = 1.
  - Misaligned write: set `align_err`, drop the request, stay in IDLE.
  - Misaligned read: set `align_err`, go to RSP with `rsp_err` = 1.
  - Otherwise go to ISSUE.
- ISSUE:
  - While `c0_busy` = 1: wait; no pulse.
  - When `c0_busy` = 0: assert `mmio_wr_valid` or `mmio_rd_valid` for exactly this cycle.
  - Write: go to IDLE.
  - Read: record `exp_tid` = `tid`, increment `tid` (wraps modulo 2^`TID_WIDTH`), clear the timer, go to WAIT_RSP.
- WAIT_RSP:
  - `c2_rd_valid` with `c2_tid` == `exp_tid`: latch data (4B read: [31:0] zero-extended), go to RSP.
  - Non-matching tid: increment `stray_cnt`, keep waiting.
  - Timer increments every cycle.
- RSP: hold `rsp_valid` until `rsp_ready`, then go to IDLE and clear `rsp_timeout`/`rsp_err`.
- `c2_rd_valid` in any state other than WAIT_RSP increments `stray_cnt`. The counter saturates at 255.
- `mmio_addr`, `mmio_length`, `mmio_tid` and `mmio_data` are registered. They are valid whenever a pulse is asserted and hold their last value otherwise.
- Reset values: all outputs 0 (`req_ready` included), `tid` = 0, FSM = IDLE.
- Reset mid-transaction abandons the transaction. No pulse and no response are emitted.

## Timing
- Request handshake in cycle N with `c0_busy` low in N+1: pulse in N+1.
- Write: `req_ready` is high again in N+2.
- Read: matching c2 response in cycle M gives `rsp_valid` in M+1. Response handshake in cycle K gives `req_ready` in K+1.
- Timeout:
  - The timer counts WAIT_RSP cycles starting at 0.
  - If it reaches `TIMEOUT_CYCLES`-1 with no match, the next cycle enters RSP with `rsp_timeout` = 1.
  - A matching response in the terminal cycle wins over the timeout.
- A late response after a timeout has a stale tid and is counted as stray.
- Only one read is outstanding at a time. Back-to-back writes are accepted at most every 2 cycles.

## Configuration
- `CCIP_MMIO_BRIDGE_TIMEOUT_EN` defined: the timer and timeout path are present as described above.
- Not defined:
  - No timer; WAIT_RSP waits indefinitely.
  - `rsp_timeout` is tied to 0.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- 8B write, addr 0x0010, data 0x1122334455667788, `c0_busy` = 0: one-cycle `mmio_wr_valid`, `mmio_length` = 1, `mmio_data[63:0]` = the write data, no `rsp_valid`.
- 4B read, addr 0x0004, c2 response 3 cycles later with tid 0 and data 0xDEADBEEF_CAFEF00D: `rsp_data` = 0x00000000_CAFEF00D, next read uses tid 1.
- `c0_busy` held high for 5 cycles during ISSUE: pulse appears only in the first cycle with `c0_busy` low; header stable throughout.
- Read with no response, `TIMEOUT_CYCLES` = 16: `rsp_valid` with `rsp_timeout` = 1 and data all ones after 16 WAIT_RSP cycles; a late tid-0 response then sets `stray_cnt` = 1.
- 8B read at addr 0x0003: no pulse, `rsp_err` = 1, `align_err` = 1; after 2^9 reads, tid wraps from 511 to 0 and responses still match.
